// File: rtl/io_input_debounce_pkg.sv
// Shared I/O constants for the input register blocks.
// Debounce timing defaults and the short value used in simulation.
package io_input_debounce_pkg;

  localparam int unsigned DB_CYCLES_DEF = 50000;
  localparam int unsigned CNT_W_DEF     = 16;
  localparam int unsigned DB_CYCLES_SIM = 4;

  // Counter value at which a differing level is accepted.
  function automatic int unsigned db_last(input int unsigned cycles);
    return cycles - 1;
  endfunction

endpackage

// File: rtl/io_input_debounce_if.sv
// Switch input bundle between board pins and the I/O input register.
// master drives raw levels, slave returns debounced levels and edges.
interface io_input_debounce_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] db_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;

  modport master (
    output sw_in,
    input  db_out,
    input  rise,
    input  fall,
    input  changed
  );

  modport slave (
    input  sw_in,
    output db_out,
    output rise,
    output fall,
    output changed
  );

endinterface

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop sync, persistence counter, stable level
// and registered rise/fall pulses.
module debounce_bit
  import io_input_debounce_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sw,
  output logic o_db,
  output logic o_rise,
  output logic o_fall,
  output logic o_evt
);

  localparam logic [CNT_W-1:0] LP_LAST =
    CNT_W'(db_last(DB_CYCLES));

  logic             r_s1;
  logic             r_s2;
  logic             r_db;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_acc;

  assign w_diff = r_s2 ^ r_db;
  assign w_acc  = w_diff && (r_cnt == LP_LAST);

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_sw;
      r_s2 <= r_s1;
    end
  end

  // Count persistence of a new level; accept it on the last count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_db   <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_acc) begin
        r_cnt  <= '0;
        r_db   <= r_s2;
        r_rise <= r_s2;
        r_fall <= ~r_s2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_db   = r_db;
  assign o_rise = r_rise;
  assign o_fall = r_fall;
  assign o_evt  = w_acc;

endmodule

// File: rtl/io_input_debounce.sv
// Debounces WIDTH switch inputs feeding the I/O input register.
// Per-bit work lives in debounce_bit; this level ORs the edges.
module io_input_debounce
  import io_input_debounce_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                      io_clk,
  input  logic                      reset,
  io_input_debounce_if.slave        bus
);

  logic [WIDTH-1:0] w_db;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_evt;
  logic             r_changed;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_bit (
      .i_clk  (io_clk),
      .i_rst  (reset),
      .i_sw   (bus.sw_in[i]),
      .o_db   (w_db[i]),
      .o_rise (w_rise[i]),
      .o_fall (w_fall[i]),
      .o_evt  (w_evt[i])
    );
  end

  // Flag any accepted edge in the same cycle its pulse appears.
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) r_changed <= 1'b0;
    else       r_changed <= |w_evt;
  end

  assign bus.db_out  = w_db;
  assign bus.rise    = w_rise;
  assign bus.fall    = w_fall;
  assign bus.changed = r_changed;

endmodule

// File: doc/io_input_debounce.md
IO_INPUT_DEBOUNCE -- requirements
Module: io_input_debounce

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the number of independent switch/key input bits.
REQ-002 Parameter DB_CYCLES, default 50000, SHALL set the number of io_clk cycles a new level must persist before acceptance; legal range 2..65535.
REQ-003 Parameter CNT_W, default 16, SHALL set the per-bit debounce counter width and SHALL satisfy 2^CNT_W > DB_CYCLES.
REQ-004 io_clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-006 sw_in  input  WIDTH  SHALL carry raw, asynchronous, bouncing switch/key levels from board pins.
REQ-007 db_out  output  WIDTH  SHALL carry debounced, registered levels and SHALL drive in_port of the I/O input register.
REQ-008 rise  output  WIDTH  SHALL pulse high for one cycle on a bit whose db_out goes 0->1.
REQ-009 fall  output  WIDTH  SHALL pulse high for one cycle on a bit whose db_out goes 1->0.
REQ-010 changed  output  1  SHALL equal the OR of all rise and fall bits, registered in the same cycle.

Function
REQ-011 Each bit SHALL pass through a two-flop synchronizer (s1, s2); only s2 SHALL feed debounce logic.
REQ-012 Per bit, while s2 equals db_out, the counter SHALL hold at 0.
REQ-013 Per bit, while s2 differs from db_out and count < DB_CYCLES-1, the counter SHALL increment by 1 per cycle.
REQ-014 Per bit, when s2 differs from db_out and count == DB_CYCLES-1, db_out SHALL take s2 and the counter SHALL return to 0 at that edge.
REQ-015 If s2 returns to db_out before acceptance, the counter SHALL clear to 0 at that edge; no output change SHALL occur.
REQ-016 Latency: a sw_in level held steady SHALL appear on db_out exactly DB_CYCLES+2 rising edges after the first edge sampling it into s1.
REQ-017 Any sw_in pulse or glitch shorter than DB_CYCLES cycles at s2 SHALL NOT change db_out, rise, fall or changed.
REQ-018 rise/fall SHALL be registered and asserted in the cycle db_out first shows the new value; never both on one bit; never longer than one cycle per transition.
REQ-019 Bits SHALL be fully independent; simultaneous transitions on several bits SHALL each produce their own rise/fall bit in the same cycle.
REQ-020 Counter SHALL never wrap; saturation at DB_CYCLES-1 precedes acceptance by construction.

Reset
REQ-021 On reset assertion, s1, s2, db_out, all counters, rise, fall and changed SHALL clear to 0 immediately, independent of io_clk.
REQ-022 Reset asserted mid-count SHALL discard partial counts; after release, a held-high input SHALL require the full DB_CYCLES+2 edges before db_out rises, with one rise pulse.
REQ-023 Release SHALL take effect at the first io_clk rising edge after reset deasserts.

Structure
REQ-024 DB_CYCLES default, CNT_W default and simulation override value (4) SHALL live in the shared I/O constants header used by the I/O register blocks.
REQ-025 Per-bit logic (synchronizer, counter, stable flop, edge pulses) SHALL be one sub-module, debounce_bit, instantiated WIDTH times via generate.
REQ-026 Top level SHALL contain only the generate loop and the changed OR-reduce register.

Verification (DB_CYCLES=4)
REQ-027 Reset, sw_in=8'h00 held -> db_out=8'h00, rise/fall/changed=0 throughout.
REQ-028 sw_in 8'h00->8'h01 held -> db_out=8'h01 exactly 6 edges after first sampling edge; rise=8'h01 and changed=1 for exactly that one cycle.
REQ-029 sw_in bit 3 toggles 1,0,1,0 each cycle then settles 0 -> db_out bit 3 unchanged, no pulses.
REQ-030 sw_in 8'h00->8'hF0 then after acceptance 8'hF0->8'h0F -> rise=8'hF0 once; later rise=8'h0F and fall=8'hF0 in the same cycle.
REQ-031 sw_in=8'hFF, reset pulsed after 2 counting cycles -> all outputs 0 immediately; db_out=8'hFF 6 edges after release, one rise=8'hFF pulse.
REQ-032 3-cycle high pulse on bit 7 (one short of DB_CYCLES) -> no change; 4-cycle pulse -> db_out bit 7 rises, then falls after return to 0 is held 4 cycles.
